elevator_scan_ctrl: RTL and testbench

//  N-floor elevator controller with latched call buttons and SCAN scheduling. It keeps

---
 rtl/elevator_pkg.sv | 34 +++
 rtl/elevator_seg7.sv | 18 +
 rtl/elevator_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator controller.
//   state_t      : controller state (IDLE, MOVE, DOOR)
//   DIR_UP/DN    : encoding of the dir output
//   seg7_decode  : decimal digit -> gfedcba segments, active-high, blank above 9
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/elevator_seg7.sv
// Floor number to 7-segment decoder (purely combinational).
//   floor    in  FLOOR_W  current floor
//   segments out 7        gfedcba, active-high
module elevator_seg7 #(
    parameter int FLOOR_W = 2
) (
    input  logic [FLOOR_W-1:0] floor,
    output logic [6:0]         segments
);
    import elevator_pkg::*;

    logic [3:0] digit;

    // Floors never exceed 9, so widening to one BCD digit is lossless.
    assign digit    = 4'(floor);
    assign segments = seg7_decode(digit);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor elevator controller with latched call buttons and SCAN scheduling:
// keeps travelling one way while calls remain ahead, then reverses.
//   clock, reset   system clock, synchronous active-high reset
//   en             step tick; timers and FSM transitions advance only on en
//   stop           level; freezes FSM and timers (call latch keeps running)
//   req            call-button pulses, one bit per floor
//   floor          current floor
//   dir            1=up, 0=down (last committed direction)
//   moving         high in MOVE
//   door_open      high in DOOR
//   pending        latched, not-yet-served calls
//   changes_count  saturating count of direction reversals
//   floor_display  7-segment decode of floor
module elevator_scan_ctrl #(
    parameter int N_FLOORS     = 4,
    parameter int TRAVEL_TICKS = 3,
    parameter int DOOR_TICKS   = 2,
    parameter int CNT_W        = 4,
    localparam int FLOOR_W     = $clog2(N_FLOORS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic                stop,
    input  logic [N_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]  floor,
    output logic                dir,
    output logic                moving,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending,
    output logic [CNT_W-1:0]    changes_count,
    output logic [6:0]          floor_display
);
    import elevator_pkg::*;

    localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int TMR_W     = $clog2(MAX_TICKS + 1);

    state_t              state_reg, state_next;
    logic [FLOOR_W-1:0]  floor_reg, floor_next;
    logic                dir_reg, dir_next;
    logic [TMR_W-1:0]    tmr_reg, tmr_next;
    logic [N_FLOORS-1:0] pending_reg, pending_next;
    logic [CNT_W-1:0]    changes_reg, changes_next;

    // Floor reached at the end of the current hop; only meaningful in MOVE,
    // where a call ahead guarantees it stays in range.
    logic [FLOOR_W-1:0]  floor_step;
    assign floor_step = (dir_reg == DIR_UP) ? floor_reg + FLOOR_W'(1)
                                            : floor_reg - FLOOR_W'(1);

    // Per-floor position masks relative to the current floor and the next hop.
    logic [N_FLOORS-1:0] here_mask, above_mask, below_mask;
    logic [N_FLOORS-1:0] step_mask, above_step_mask, below_step_mask;

    for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_masks
        assign here_mask[gi]       = (FLOOR_W'(gi) == floor_reg);
        assign above_mask[gi]      = (FLOOR_W'(gi) >  floor_reg);
        assign below_mask[gi]      = (FLOOR_W'(gi) <  floor_reg);
        assign step_mask[gi]       = (FLOOR_W'(gi) == floor_step);
        assign above_step_mask[gi] = (FLOOR_W'(gi) >  floor_step);
        assign below_step_mask[gi] = (FLOOR_W'(gi) <  floor_step);
    end

    logic here, ahead_up, ahead_dn, arrive_call, ahead_after_step;
    assign here             = |(pending_reg & here_mask);
    assign ahead_up         = |(pending_reg & above_mask);
    assign ahead_dn         = |(pending_reg & below_mask);
    assign arrive_call      = |(pending_reg & step_mask);
    assign ahead_after_step = (dir_reg == DIR_UP) ? |(pending_reg & above_step_mask)
                                                  : |(pending_reg & below_step_mask);

    // While the door is open the call at this floor is being served, so it
    // is masked out; a fresh press here only extends the dwell.
    logic [N_FLOORS-1:0] clr;
    logic                door_repress;
    assign clr          = (state_reg == DOOR) ? here_mask : '0;
    assign door_repress = (state_reg == DOOR) && |(req & here_mask);
    assign pending_next = (pending_reg | req) & ~clr;

    always_comb begin
        state_next   = state_reg;
        floor_next   = floor_reg;
        dir_next     = dir_reg;
        tmr_next     = tmr_reg;
        changes_next = changes_reg;

        if (!stop) begin
            if (door_repress) begin
                tmr_next = '0;
            end else if (en) begin
                case (state_reg)
                    IDLE: begin
                        tmr_next = '0;
                        if (here) begin
                            state_next = DOOR;
                        end else if ((dir_reg == DIR_UP) ? ahead_up : ahead_dn) begin
                            state_next = MOVE;
                        end else if ((dir_reg == DIR_UP) ? ahead_dn : ahead_up) begin
                            state_next = MOVE;
                            dir_next   = ~dir_reg;
                            if (changes_reg != {CNT_W{1'b1}})
                                changes_next = changes_reg + CNT_W'(1);
                        end
                    end
                    MOVE: begin
                        if (tmr_reg == TMR_W'(TRAVEL_TICKS - 1)) begin
                            tmr_next   = '0;
                            floor_next = floor_step;
                            if (arrive_call)
                                state_next = DOOR;
                            else if (!ahead_after_step)
                                state_next = IDLE;
                        end else begin
                            tmr_next = tmr_reg + TMR_W'(1);
                        end
                    end
                    DOOR: begin
                        if (tmr_reg == TMR_W'(DOOR_TICKS - 1)) begin
                            tmr_next   = '0;
                            state_next = IDLE;
                        end else begin
                            tmr_next = tmr_reg + TMR_W'(1);
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        tmr_next   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            floor_reg   <= '0;
            dir_reg     <= DIR_UP;
            tmr_reg     <= '0;
            pending_reg <= '0;
            changes_reg <= '0;
        end else begin
            state_reg   <= state_next;
            floor_reg   <= floor_next;
            dir_reg     <= dir_next;
            tmr_reg     <= tmr_next;
            pending_reg <= pending_next;
            changes_reg <= changes_next;
        end
    end

    assign floor         = floor_reg;
    assign dir           = dir_reg;
    assign moving        = (state_reg == MOVE);
    assign door_open     = (state_reg == DOOR);
    assign pending       = pending_reg;
    assign changes_count = changes_reg;

    elevator_seg7 #(
        .FLOOR_W (FLOOR_W)
    ) u_seg7 (
        .floor    (floor_reg),
        .segments (floor_display)
    );

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: two instances share stimulus (CNT_W=4 and
// CNT_W=2); a behavioural model is compared every cycle, and directed
// scenarios add hand-computed literal checks.
module tb_elevator_scan_ctrl;

    logic       clk;
    logic       reset, en, stop;
    logic [3:0] req;

    logic [1:0] floor_a, floor_b;
    logic       dir_a, dir_b, moving_a, moving_b, door_a, door_b;
    logic [3:0] pend_a, pend_b;
    logic [3:0] cc_a;
    logic [1:0] cc_b;
    logic [6:0] disp_a, disp_b;

    int n_cmp = 0;
    int n_bad = 0;

    elevator_scan_ctrl #(.N_FLOORS(4), .TRAVEL_TICKS(3), .DOOR_TICKS(2), .CNT_W(4)) dut (
        .clock(clk), .reset(reset), .en(en), .stop(stop), .req(req),
        .floor(floor_a), .dir(dir_a), .moving(moving_a), .door_open(door_a),
        .pending(pend_a), .changes_count(cc_a), .floor_display(disp_a));

    elevator_scan_ctrl #(.N_FLOORS(4), .TRAVEL_TICKS(3), .DOOR_TICKS(2), .CNT_W(2)) dut_c2 (
        .clock(clk), .reset(reset), .en(en), .stop(stop), .req(req),
        .floor(floor_b), .dir(dir_b), .moving(moving_b), .door_open(door_b),
        .pending(pend_b), .changes_count(cc_b), .floor_display(disp_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 travelling, 2 door open
    int       m_floor, m_dir, m_mode, m_ticks, m_changes;
    bit [3:0] m_calls;
    bit       m_valid = 0;
    int       seg_table [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    function automatic bit calls_beyond(bit [3:0] calls, int from, int up);
        for (int k = 0; k < 4; k++)
            if (calls[k] && ((up != 0) ? (k > from) : (k < from))) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_floor = 0; m_dir = 1; m_mode = 0; m_ticks = 0;
            m_calls = 0; m_changes = 0; m_valid = 1;
        end else begin
            bit [3:0] seen, upd;
            seen = m_calls;
            upd  = m_calls | req;
            if (m_mode == 2) upd[m_floor] = 1'b0;
            if (!stop) begin
                if (m_mode == 2 && req[m_floor]) begin
                    m_ticks = 0;
                end else if (en) begin
                    if (m_mode == 0) begin
                        if (seen[m_floor]) m_mode = 2;
                        else if (calls_beyond(seen, m_floor, m_dir)) m_mode = 1;
                        else if (calls_beyond(seen, m_floor, 1 - m_dir)) begin
                            m_dir = 1 - m_dir; m_changes++; m_mode = 1;
                        end
                        m_ticks = 0;
                    end else if (m_mode == 1) begin
                        m_ticks++;
                        if (m_ticks == 3) begin
                            m_ticks = 0;
                            m_floor = m_floor + ((m_dir != 0) ? 1 : -1);
                            if (seen[m_floor]) m_mode = 2;
                            else if (!calls_beyond(seen, m_floor, m_dir)) m_mode = 0;
                        end
                    end else begin
                        m_ticks++;
                        if (m_ticks == 2) begin m_ticks = 0; m_mode = 0; end
                    end
                end
            end
            m_calls = upd;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model floor",   int'(floor_a),  m_floor);
            chk("model dir",     int'(dir_a),    m_dir);
            chk("model moving",  int'(moving_a), (m_mode == 1) ? 1 : 0);
            chk("model door",    int'(door_a),   (m_mode == 2) ? 1 : 0);
            chk("model pending", int'(pend_a),   int'(m_calls));
            chk("model count4",  int'(cc_a),     (m_changes > 15) ? 15 : m_changes);
            chk("model display", int'(disp_a),   seg_table[m_floor]);
            chk("model floor c2",  int'(floor_b), m_floor);
            chk("model door c2",   int'(door_b),  (m_mode == 2) ? 1 : 0);
            chk("model pending c2", int'(pend_b), int'(m_calls));
            chk("model count2",    int'(cc_b),    (m_changes > 3) ? 3 : m_changes);
            chk("model display c2", int'(disp_b), seg_table[m_floor]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " floor"},   int'(floor_a), 0);
        chk({tag, " dir"},     int'(dir_a),   1);
        chk({tag, " moving"},  int'(moving_a), 0);
        chk({tag, " door"},    int'(door_a),  0);
        chk({tag, " pending"}, int'(pend_a),  0);
        chk({tag, " count"},   int'(cc_a),    0);
        chk({tag, " display"}, int'(disp_a),  'h3F);
        chk({tag, " count c2"}, int'(cc_b),   0);
    endtask

    int first_door;

    initial begin
        reset = 1'b1; en = 1'b1; stop = 1'b0; req = 4'b0000;
        step(2);
        reset = 1'b0;
        chk_reset_values("reset");

        // Top-floor call from reset: departs up without counting a change.
        req = 4'b1000; step(1); req = 4'b0000;
        chk("t2 pending latched", int'(pend_a), 8);
        step(1);  chk("t2 moving", int'(moving_a), 1);
        step(3);  chk("t2 floor1", int'(floor_a), 1);
        step(6);  chk("t2 floor3", int'(floor_a), 3);
                  chk("t2 door open", int'(door_a), 1);
                  chk("t2 display 3", int'(disp_a), 'h4F);
        step(1);  chk("t2 pending cleared", int'(pend_a), 0);
                  chk("t2 door still open", int'(door_a), 1);
        step(1);  chk("t2 door closed", int'(door_a), 0);
                  chk("t2 no change", int'(cc_a), 0);

        // Reverse to floor 0.
        req = 4'b0001; step(1); req = 4'b0000;
        step(1);  chk("t3 dir down", int'(dir_a), 0);
                  chk("t3 count 1", int'(cc_a), 1);
        step(9);  chk("t3 floor0", int'(floor_a), 0);
                  chk("t3 door open", int'(door_a), 1);
        step(4);

        // SCAN: calls at 2 then 1, served in order going up.
        req = 4'b0100; step(1); req = 4'b0010; step(1); req = 4'b0000;
        chk("t4 count 2", int'(cc_a), 2);
        chk("t4 dir up", int'(dir_a), 1);
        step(3);  chk("t4 stop at 1", int'(floor_a), 1);
                  chk("t4 door at 1", int'(door_a), 1);
        step(6);  chk("t4 stop at 2", int'(floor_a), 2);
                  chk("t4 door at 2", int'(door_a), 1);
                  chk("t4 still count 2", int'(cc_a), 2);
        step(2);
        req = 4'b0001; step(1); req = 4'b0000;
        step(1);  chk("t4 reversal count 3", int'(cc_a), 3);
        step(6);  chk("t4 back at 0", int'(floor_a), 0);
        step(4);

        // stop for 5 cycles mid-travel.
        req = 4'b1000; step(1); req = 4'b0000;
        step(2);
        stop = 1'b1; step(5);
        chk("t5 frozen floor", int'(floor_a), 0);
        chk("t5 frozen moving", int'(moving_a), 1);
        stop = 1'b0;
        step(1);  chk("t5 not yet", int'(floor_a), 0);
        step(1);  chk("t5 late arrival", int'(floor_a), 1);
        step(6);  chk("t5 door at 3", int'(door_a), 1);
        stop = 1'b1; step(3);
        chk("t5 door held", int'(door_a), 1);
        stop = 1'b0;
        step(1);  chk("t5 door remaining tick", int'(door_a), 1);
        step(1);  chk("t5 door closed", int'(door_a), 0);
        step(2);

        // en every 4th cycle: trip 3 -> 0 stretched by 4.
        first_door = -1;
        for (int i = 0; i < 60; i++) begin
            en  = (i % 4 == 0);
            req = (i == 0) ? 4'b0001 : 4'b0000;
            step(1);
            if (door_a && first_door < 0) first_door = i;
        end
        en = 1'b1;
        chk("t5 scaled arrival", first_door, 40);
        chk("t6 count 5", int'(cc_a), 5);
        chk("t6 count saturated", int'(cc_b), 3);

        // Reset mid-travel.
        req = 4'b1000; step(1); req = 4'b0000;
        step(3);
        chk("t6 moving before reset", int'(moving_a), 1);
        reset = 1'b1; step(1);
        chk_reset_values("t6 reset");
        reset = 1'b0;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
